// File: rtl/atomrvcore_dccm_pkg.sv
// Shared types for the DCCM arbiter.
// FSM states, port ownership and default widths.
package atomrvcore_dccm_pkg;

    localparam int DCCM_DW = 32;
    localparam int DCCM_AW = 10;
    localparam int BE_W    = DCCM_DW / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_RESP,
        WR,
        RMW_RD,
        RMW_WR
    } state_e;

    typedef enum logic {
        OWN_CORE,
        OWN_EXT
    } owner_e;

endpackage

// File: rtl/atomrvcore_rr_arb2.sv
// Two-request round-robin arbiter.
// Bit 0 is the core port, bit 1 the ext port.
module atomrvcore_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_ext_q;

    // A lone request always wins; on conflict the previous loser wins.
    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_ext_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Last-winner pointer; reset as if ext won so core goes first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_ext_q <= 1'b1;
        end else if (advance && (|grant)) begin
            last_ext_q <= grant[1];
        end
    end

endmodule

// File: rtl/atomrvcore_dccm_arbiter.sv
// Shares the single-port DCCM between the core LSU and an ext master.
// Sub-word stores are sequenced as read-modify-write.
module atomrvcore_dccm_arbiter
    import atomrvcore_dccm_pkg::*;
#(
    parameter int DATAWIDTH   = DCCM_DW,
    parameter int ADDRESS_BUS = DCCM_AW
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   core_req_i,
    input  logic                   core_we_i,
    input  logic [DATAWIDTH/8-1:0] core_be_i,
    input  logic [DATAWIDTH-1:0]   core_addr_i,
    input  logic [DATAWIDTH-1:0]   core_wdata_i,
    output logic                   core_gnt_o,
    output logic                   core_rvalid_o,
    output logic [DATAWIDTH-1:0]   core_rdata_o,
    output logic                   core_err_o,
    input  logic                   ext_req_i,
    input  logic                   ext_we_i,
    input  logic [DATAWIDTH/8-1:0] ext_be_i,
    input  logic [DATAWIDTH-1:0]   ext_addr_i,
    input  logic [DATAWIDTH-1:0]   ext_wdata_i,
    output logic                   ext_gnt_o,
    output logic                   ext_rvalid_o,
    output logic [DATAWIDTH-1:0]   ext_rdata_o,
    output logic                   ext_err_o,
    output logic                   mem_rd_en_o,
    output logic                   mem_wr_en_o,
    output logic [ADDRESS_BUS-1:0] mem_addr_o,
    output logic [DATAWIDTH-1:0]   mem_wdata_o,
    input  logic [DATAWIDTH-1:0]   mem_rdata_i
);

    localparam int BW = DATAWIDTH / 8;

    state_e                 state_q;
    state_e                 state_d;
    owner_e                 owner_q;
    logic [BW-1:0]          be_q;
    logic [ADDRESS_BUS-1:0] waddr_q;
    logic [DATAWIDTH-1:0]   wdata_q;
    logic                   err_q;
    logic                   wstb_q;

    logic [1:0]           req;
    logic [1:0]           grant;
    logic                 advance;
    logic                 sel_ext;
    logic                 sel_we;
    logic [BW-1:0]        sel_be;
    logic [DATAWIDTH-1:0] sel_addr;
    logic [DATAWIDTH-1:0] sel_wdata;
    logic                 sel_oor;
    logic                 sel_full;
    logic                 sel_none;
    logic                 go_wr;
    logic                 go_rd;
    logic                 go_rmw;
    logic                 ack;
    logic                 load_ack;
    logic [DATAWIDTH-1:0] merged;
    logic                 unused_addr_lsb;

    assign req     = {ext_req_i, core_req_i} & {2{state_q == IDLE}};
    assign advance = |req;

    atomrvcore_rr_arb2 u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    assign sel_ext   = grant[1];
    assign sel_we    = sel_ext ? ext_we_i    : core_we_i;
    assign sel_be    = sel_ext ? ext_be_i    : core_be_i;
    assign sel_addr  = sel_ext ? ext_addr_i  : core_addr_i;
    assign sel_wdata = sel_ext ? ext_wdata_i : core_wdata_i;

    assign sel_oor  = |sel_addr[DATAWIDTH-1:ADDRESS_BUS+2];
    assign sel_full = &sel_be;
    assign sel_none = ~|sel_be;

    assign go_wr  = sel_oor || (sel_we && (sel_full || sel_none));
    assign go_rd  = !sel_oor && !sel_we;
    assign go_rmw = !sel_oor && sel_we && !sel_full && !sel_none;

    assign unused_addr_lsb = ^sel_addr[1:0];

    // Capture the winning request so memory outputs never see req inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OWN_CORE;
            be_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            wstb_q  <= 1'b0;
        end else if (advance) begin
            owner_q <= sel_ext ? OWN_EXT : OWN_CORE;
            be_q    <= sel_be;
            waddr_q <= sel_addr[ADDRESS_BUS+1:2];
            wdata_q <= sel_wdata;
            err_q   <= sel_oor;
            wstb_q  <= !sel_oor && sel_we && sel_full;
        end
    end

    // Sub-word store: keep old bytes where be is clear.
    always_comb begin
        merged = '0;
        for (int i = 0; i < BW; i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8]
                                       : mem_rdata_i[8*i +: 8];
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and memory/ack strobes.
    always_comb begin
        state_d     = state_q;
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;
        mem_wdata_o = '0;
        ack         = 1'b0;
        load_ack    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (advance) begin
                    unique case (1'b1)
                        go_wr:   state_d = WR;
                        go_rd:   state_d = RD;
                        go_rmw:  state_d = RMW_RD;
                        default: state_d = IDLE;
                    endcase
                end
            end
            RD: begin
                mem_rd_en_o = 1'b1;
                state_d     = RD_RESP;
            end
            RD_RESP: begin
                ack      = 1'b1;
                load_ack = 1'b1;
                state_d  = IDLE;
            end
            WR: begin
                mem_wr_en_o = wstb_q;
                mem_wdata_o = wstb_q ? wdata_q : '0;
                ack         = 1'b1;
                state_d     = IDLE;
            end
            RMW_RD: begin
                mem_rd_en_o = 1'b1;
                state_d     = RMW_WR;
            end
            RMW_WR: begin
                mem_wr_en_o = 1'b1;
                mem_wdata_o = merged;
                ack         = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr_o = waddr_q;

    assign core_gnt_o = grant[0];
    assign ext_gnt_o  = grant[1];

    assign core_rvalid_o = ack && (owner_q == OWN_CORE);
    assign ext_rvalid_o  = ack && (owner_q == OWN_EXT);
    assign core_err_o    = core_rvalid_o && err_q;
    assign ext_err_o     = ext_rvalid_o && err_q;

    assign core_rdata_o = (load_ack && owner_q == OWN_CORE)
                        ? mem_rdata_i : '0;
    assign ext_rdata_o  = (load_ack && owner_q == OWN_EXT)
                        ? mem_rdata_i : '0;

endmodule

// File: tb/tb_atomrvcore_dccm_arbiter.sv
// Bench for the DCCM arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_atomrvcore_dccm_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        core_req_i, core_we_i, ext_req_i, ext_we_i;
    logic [3:0]  core_be_i, ext_be_i;
    logic [31:0] core_addr_i, core_wdata_i, ext_addr_i, ext_wdata_i;
    logic        core_gnt_o, core_rvalid_o, core_err_o;
    logic        ext_gnt_o, ext_rvalid_o, ext_err_o;
    logic [31:0] core_rdata_o, ext_rdata_o;
    logic        mem_rd_en_o, mem_wr_en_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] dccm_rdata;

    logic [31:0] dccm [0:1023];
    logic [31:0] ref_mem [0:1023];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    // DCCM array: whole-word writes, registered reads.
    always @(posedge clk_i) begin
        if (mem_wr_en_o) dccm[mem_addr_o] <= mem_wdata_o;
        if (mem_rd_en_o) dccm_rdata <= dccm[mem_addr_o];
    end

    atomrvcore_dccm_arbiter dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_be_i    (core_be_i),
        .core_addr_i  (core_addr_i),
        .core_wdata_i (core_wdata_i),
        .core_gnt_o   (core_gnt_o),
        .core_rvalid_o(core_rvalid_o),
        .core_rdata_o (core_rdata_o),
        .core_err_o   (core_err_o),
        .ext_req_i    (ext_req_i),
        .ext_we_i     (ext_we_i),
        .ext_be_i     (ext_be_i),
        .ext_addr_i   (ext_addr_i),
        .ext_wdata_i  (ext_wdata_i),
        .ext_gnt_o    (ext_gnt_o),
        .ext_rvalid_o (ext_rvalid_o),
        .ext_rdata_o  (ext_rdata_o),
        .ext_err_o    (ext_err_o),
        .mem_rd_en_o  (mem_rd_en_o),
        .mem_wr_en_o  (mem_wr_en_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (dccm_rdata)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        core_req_i = 0; core_we_i = 0; core_be_i = 0;
        core_addr_i = 0; core_wdata_i = 0;
        ext_req_i = 0; ext_we_i = 0; ext_be_i = 0;
        ext_addr_i = 0; ext_wdata_i = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_ni = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1;
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        idle_inputs();
        rst_ni = 0;
        repeat (2) @(posedge clk_i);
        #1;
        flags = {core_gnt_o, ext_gnt_o, core_rvalid_o, ext_rvalid_o,
                 core_err_o, ext_err_o, mem_rd_en_o, mem_wr_en_o};
        n_cmp++;
        if (flags !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 00000000", flags);
        end
        n_cmp++;
        if ((core_rdata_o | ext_rdata_o) !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h/%h expected 0",
                     core_rdata_o, ext_rdata_o);
        end
        rst_ni = 1;
        #1;
    endtask

    task automatic test_core_load();
        dccm[4] = 32'hDEADBEEF;
        core_req_i = 1; core_we_i = 0; core_be_i = 4'h0;
        core_addr_i = 32'h10;
        #1;
        n_cmp++;
        if ({core_gnt_o, ext_gnt_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL load_gnt: got %b expected 10",
                     {core_gnt_o, ext_gnt_o});
        end
        tick();
        core_req_i = 0;
        #1;
        n_cmp++;
        if ({mem_rd_en_o, mem_wr_en_o, mem_addr_o, core_rvalid_o}
            !== {2'b10, 10'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL load_rd: got rd=%b wr=%b addr=%0d rv=%b expected 1 0 4 0",
                     mem_rd_en_o, mem_wr_en_o, mem_addr_o, core_rvalid_o);
        end
        tick();
        n_cmp++;
        if ({core_rvalid_o, core_err_o, core_rdata_o}
            !== {2'b10, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL load_resp: got rv=%b err=%b data=%h expected 1 0 deadbeef",
                     core_rvalid_o, core_err_o, core_rdata_o);
        end
        tick();
        n_cmp++;
        if ({core_rvalid_o, core_rdata_o} !== 33'h0) begin
            n_bad++;
            $display("FAIL load_after: got rv=%b data=%h expected 0 0",
                     core_rvalid_o, core_rdata_o);
        end
    endtask

    task automatic test_rmw();
        dccm[8] = 32'h11223344;
        ext_req_i = 1; ext_we_i = 1; ext_be_i = 4'b0010;
        ext_addr_i = 32'h20; ext_wdata_i = 32'h0000AB00;
        #1;
        n_cmp++;
        if ({core_gnt_o, ext_gnt_o} !== 2'b01) begin
            n_bad++;
            $display("FAIL rmw_gnt: got %b expected 01",
                     {core_gnt_o, ext_gnt_o});
        end
        tick();
        ext_req_i = 0;
        #1;
        n_cmp++;
        if ({mem_rd_en_o, mem_wr_en_o, ext_rvalid_o} !== 3'b100) begin
            n_bad++;
            $display("FAIL rmw_rd: got %b expected 100",
                     {mem_rd_en_o, mem_wr_en_o, ext_rvalid_o});
        end
        tick();
        n_cmp++;
        if ({mem_rd_en_o, mem_wr_en_o, ext_rvalid_o, ext_err_o,
             mem_wdata_o} !== {4'b0110, 32'h1122AB44}) begin
            n_bad++;
            $display("FAIL rmw_wr: got %b data=%h expected 0110 1122ab44",
                     {mem_rd_en_o, mem_wr_en_o, ext_rvalid_o, ext_err_o},
                     mem_wdata_o);
        end
        tick();
        n_cmp++;
        if (dccm[8] !== 32'h1122AB44) begin
            n_bad++;
            $display("FAIL rmw_mem: got %h expected 1122ab44", dccm[8]);
        end
    endtask

    task automatic test_out_of_range();
        core_req_i = 1; core_we_i = 0; core_be_i = 4'hF;
        core_addr_i = 32'h1000;
        #1;
        n_cmp++;
        if (core_gnt_o !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_gnt: got %b expected 1", core_gnt_o);
        end
        tick();
        core_req_i = 0;
        #1;
        n_cmp++;
        if ({core_rvalid_o, core_err_o, mem_rd_en_o, mem_wr_en_o,
             core_rdata_o} !== {4'b1100, 32'h0}) begin
            n_bad++;
            $display("FAIL oor_ack: got %b data=%h expected 1100 0",
                     {core_rvalid_o, core_err_o, mem_rd_en_o, mem_wr_en_o},
                     core_rdata_o);
        end
        tick();
        n_cmp++;
        if ({core_rvalid_o, core_err_o, mem_rd_en_o} !== 3'b000) begin
            n_bad++;
            $display("FAIL oor_after: got %b expected 000",
                     {core_rvalid_o, core_err_o, mem_rd_en_o});
        end
    endtask

    task automatic test_full_store_readback();
        core_req_i = 1; core_we_i = 1; core_be_i = 4'hF;
        core_addr_i = 32'h40; core_wdata_i = 32'hCAFEF00D;
        #1;
        tick();
        core_req_i = 0;
        #1;
        n_cmp++;
        if ({mem_wr_en_o, mem_rd_en_o, core_rvalid_o, mem_addr_o,
             mem_wdata_o} !== {3'b101, 10'd16, 32'hCAFEF00D}) begin
            n_bad++;
            $display("FAIL full_wr: got %b addr=%0d data=%h expected 101 16 cafef00d",
                     {mem_wr_en_o, mem_rd_en_o, core_rvalid_o},
                     mem_addr_o, mem_wdata_o);
        end
        tick();
        core_req_i = 1; core_we_i = 0;
        #1;
        n_cmp++;
        if ({mem_wr_en_o, core_gnt_o} !== 2'b01) begin
            n_bad++;
            $display("FAIL full_single: got wr=%b gnt=%b expected 0 1",
                     mem_wr_en_o, core_gnt_o);
        end
        tick();
        core_req_i = 0;
        tick();
        n_cmp++;
        if ({core_rvalid_o, core_rdata_o} !== {1'b1, 32'hCAFEF00D}) begin
            n_bad++;
            $display("FAIL full_readback: got rv=%b data=%h expected 1 cafef00d",
                     core_rvalid_o, core_rdata_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int got[$];
        int cyc;
        int lone;
        apply_reset();
        core_req_i = 1; core_we_i = 1; core_be_i = 4'hF;
        core_addr_i = 32'h80; core_wdata_i = 32'h0A0A0A0A;
        ext_req_i = 1; ext_we_i = 1; ext_be_i = 4'hF;
        ext_addr_i = 32'h84; ext_wdata_i = 32'h0B0B0B0B;
        cyc = 0;
        while (got.size() < 4 && cyc < 40) begin
            #1;
            if (core_gnt_o || ext_gnt_o) got.push_back(int'(ext_gnt_o));
            tick();
            cyc++;
        end
        n_cmp++;
        if (got.size() != 4) begin
            n_bad++;
            $display("FAIL rr_count: got %0d grants expected 4", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++;
            if (got[i] != (i % 2)) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d",
                         i, got[i], i % 2);
            end
        end
        core_req_i = 0;
        lone = -1;
        cyc = 0;
        while (lone < 0 && cyc < 10) begin
            #1;
            if (core_gnt_o || ext_gnt_o) lone = int'(ext_gnt_o);
            tick();
            cyc++;
        end
        ext_req_i = 0;
        n_cmp++;
        if (lone != 1) begin
            n_bad++;
            $display("FAIL rr_lone: got %0d expected 1 (ext)", lone);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_rmw();
        logic [7:0] flags;
        dccm[12] = 32'h55667788;
        ext_req_i = 1; ext_we_i = 1; ext_be_i = 4'b1000;
        ext_addr_i = 32'h30; ext_wdata_i = 32'hAA000000;
        #1;
        tick();
        ext_req_i = 0;
        #1;
        n_cmp++;
        if (mem_rd_en_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_rmw_rd: got %b expected 1", mem_rd_en_o);
        end
        rst_ni = 0;
        #1;
        flags = {core_gnt_o, ext_gnt_o, core_rvalid_o, ext_rvalid_o,
                 core_err_o, ext_err_o, mem_rd_en_o, mem_wr_en_o};
        n_cmp++;
        if (flags !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_rmw_flags: got %b expected 00000000", flags);
        end
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++;
        if ({dccm[12], ext_rvalid_o} !== {32'h55667788, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_rmw_mem: got %h rv=%b expected 55667788 0",
                     dccm[12], ext_rvalid_o);
        end
        rst_ni = 1;
        #1;
        core_req_i = 1; core_we_i = 0; core_addr_i = 32'h30;
        #1;
        n_cmp++;
        if (core_gnt_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_rmw_idle: got gnt=%b expected 1", core_gnt_o);
        end
        tick();
        core_req_i = 0;
        tick();
        n_cmp++;
        if (core_rdata_o !== 32'h55667788) begin
            n_bad++;
            $display("FAIL rst_rmw_readback: got %h expected 55667788",
                     core_rdata_o);
        end
        tick();
    endtask

    task automatic test_random();
        bit          pend[2];
        logic        p_we[2];
        logic [3:0]  p_be[2];
        logic [31:0] p_addr[2];
        logic [31:0] p_wdata[2];
        int          last_w;
        int          next_free;
        bit          infl;
        int          ack_cyc;
        int          ack_port;
        bit          ack_err;
        bit          ack_chk;
        logic [31:0] ack_data;
        logic [1:0]  eg;
        logic [1:0]  erv;
        logic [31:0] old;
        int          w;
        int          word;
        int          lat;
        int          r;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            dccm[i] = $urandom;
            ref_mem[i] = dccm[i];
        end
        pend[0] = 0; pend[1] = 0;
        last_w = 1; next_free = 0; infl = 0;
        ack_cyc = 0; ack_port = 0; ack_err = 0; ack_chk = 0; ack_data = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1;
                    p_we[p] = 1'($urandom_range(0, 1));
                    r = $urandom_range(0, 3);
                    p_be[p] = (r == 0) ? 4'hF : (r == 1) ? 4'h0
                            : 4'($urandom_range(1, 14));
                    if ($urandom_range(0, 7) == 0)
                        p_addr[p] = $urandom | 32'h1000;
                    else
                        p_addr[p] = ($urandom_range(0, 15) << 2)
                                  | $urandom_range(0, 3);
                    p_wdata[p] = $urandom;
                end
            end
            core_req_i = pend[0]; core_we_i = p_we[0]; core_be_i = p_be[0];
            core_addr_i = p_addr[0]; core_wdata_i = p_wdata[0];
            ext_req_i = pend[1]; ext_we_i = p_we[1]; ext_be_i = p_be[1];
            ext_addr_i = p_addr[1]; ext_wdata_i = p_wdata[1];
            #1;
            eg = 2'b00;
            w = -1;
            if (cyc >= next_free && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) w = (last_w == 0) ? 1 : 0;
                else w = pend[1] ? 1 : 0;
                eg[w] = 1'b1;
            end
            n_cmp++;
            if ({ext_gnt_o, core_gnt_o} !== eg) begin
                n_bad++;
                $display("FAIL rnd_gnt@%0d: got %b expected %b",
                         cyc, {ext_gnt_o, core_gnt_o}, eg);
            end
            erv = 2'b00;
            if (infl && cyc == ack_cyc) erv[ack_port] = 1'b1;
            n_cmp++;
            if ({ext_rvalid_o, core_rvalid_o} !== erv) begin
                n_bad++;
                $display("FAIL rnd_rvalid@%0d: got %b expected %b",
                         cyc, {ext_rvalid_o, core_rvalid_o}, erv);
            end
            n_cmp++;
            if ({ext_rvalid_o, core_rvalid_o} === erv && erv == 2'b00
                && (core_rdata_o | ext_rdata_o | {31'h0, core_err_o}
                    | {31'h0, ext_err_o}) !== 32'h0) begin
                n_bad++;
                $display("FAIL rnd_idle_out@%0d: got %h/%h expected 0",
                         cyc, core_rdata_o, ext_rdata_o);
            end
            if (erv != 2'b00) begin
                n_cmp++;
                if ((ack_port ? ext_err_o : core_err_o) !== ack_err) begin
                    n_bad++;
                    $display("FAIL rnd_err@%0d: got %b expected %b", cyc,
                             ack_port ? ext_err_o : core_err_o, ack_err);
                end
                if (ack_chk) begin
                    n_cmp++;
                    if ((ack_port ? ext_rdata_o : core_rdata_o) !== ack_data) begin
                        n_bad++;
                        $display("FAIL rnd_rdata@%0d: got %h expected %h", cyc,
                                 ack_port ? ext_rdata_o : core_rdata_o,
                                 ack_data);
                    end
                end
                infl = 0;
            end
            n_cmp++;
            if ((mem_rd_en_o && mem_wr_en_o) !== 1'b0) begin
                n_bad++;
                $display("FAIL rnd_strobes@%0d: got rd=%b wr=%b expected not both",
                         cyc, mem_rd_en_o, mem_wr_en_o);
            end
            if (w >= 0) begin
                last_w = w;
                pend[w] = 0;
                word = int'(p_addr[w][11:2]);
                ack_port = w;
                ack_err = (p_addr[w][31:12] != 0);
                ack_chk = 1;
                ack_data = 32'h0;
                if (ack_err) begin
                    lat = 1;
                end else if (!p_we[w]) begin
                    lat = 2;
                    ack_data = ref_mem[word];
                end else begin
                    ack_chk = 0;
                    old = ref_mem[word];
                    lat = (p_be[w] == 4'hF || p_be[w] == 4'h0) ? 1 : 2;
                    for (int b = 0; b < 4; b++)
                        if (p_be[w][b]) old[8*b +: 8] = p_wdata[w][8*b +: 8];
                    ref_mem[word] = old;
                end
                ack_cyc = cyc + lat;
                next_free = cyc + lat + 1;
                infl = 1;
            end
            tick();
        end
        idle_inputs();
        repeat (4) tick();
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (dccm[i] !== ref_mem[i]) begin
                n_bad++;
                $display("FAIL rnd_mem[%0d]: got %h expected %h",
                         i, dccm[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_core_load();
        test_rmw();
        test_out_of_range();
        test_full_store_readback();
        test_back_to_back();
        test_reset_mid_rmw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
